// File: rtl/deglitch_filter.sv
// Deglitch filter: synchronizes D0, then moves Q0 only after STABLE_CNT consecutive enabled samples differ from it.
// Optional registered RISE0/FALL0 edge pulses when DEGLITCH_FILTER_EDGE_OUT_EN is defined; tied low otherwise.
module deglitch_filter #(
  parameter int   SYNC_STAGES = 2,
  parameter int   STABLE_CNT  = 4,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic CK,
  input  logic CD,
  input  logic CE,
  input  logic D0,
  output logic Q0,
  output logic QN0,
  output logic RISE0,
  output logic FALL0
);

  localparam int CNT_W = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {STABLE, PENDING} state_t;

  logic [SYNC_STAGES-1:0] sync_p0;
  logic [CNT_W-1:0]       cnt_q, cnt_nxt;
  state_t                 state_q, state_nxt;
  logic                   q_nxt;
  logic                   s;
  logic                   diff;

  // Stage p0: synchronizer chain, shifts every edge regardless of CE
  always_ff @(posedge CK) begin
    if (CD) sync_p0 <= {SYNC_STAGES{RESET_VAL}};
    else    sync_p0 <= {sync_p0[SYNC_STAGES-2:0], D0};
  end

  assign s = sync_p0[SYNC_STAGES-1];
  // An X on s makes diff X, which falls into the "no change" branch below.
  assign diff = (s != Q0);

  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    q_nxt     = Q0;
    if (CE) begin
      case (state_q)
        STABLE: begin
          if (diff) begin
            if (cnt_q == CNT_MAX) begin
              q_nxt = s;
            end else begin
              cnt_nxt   = cnt_q + CNT_ONE;
              state_nxt = PENDING;
            end
          end
        end
        PENDING: begin
          if (diff) begin
            if (cnt_q == CNT_MAX) begin
              q_nxt     = s;
              cnt_nxt   = '0;
              state_nxt = STABLE;
            end else begin
              cnt_nxt = cnt_q + CNT_ONE;
            end
          end else begin
            cnt_nxt   = '0;
            state_nxt = STABLE;
          end
        end
      endcase
    end
  end

  // Stage p1: filter state and registered output pair
  always_ff @(posedge CK) begin
    if (CD) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      Q0      <= RESET_VAL;
      QN0     <= ~RESET_VAL;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      Q0      <= q_nxt;
      QN0     <= ~q_nxt;
    end
  end

`ifdef DEGLITCH_FILTER_EDGE_OUT_EN
  logic rise_q, fall_q;

  // Stage p2: edge pulses; reset-driven Q0 changes never pulse
  always_ff @(posedge CK) begin
    if (CD) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= q_nxt & ~Q0;
      fall_q <= ~q_nxt & Q0;
    end
  end

  assign RISE0 = rise_q;
  assign FALL0 = fall_q;
`else
  assign RISE0 = 1'b0;
  assign FALL0 = 1'b0;
`endif

endmodule

// File: tb/tb_deglitch_filter.sv
// Directed bench for deglitch_filter: default instance plus a STABLE_CNT=1 / SYNC_STAGES=3 instance.
module tb_deglitch_filter;

`ifdef DEGLITCH_FILTER_EDGE_OUT_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic ck = 1'b0;
  logic cd, ce, d0, cdb, d0b;
  logic q0, qn0, rise0, fall0;
  logic q0b, qn0b, rise0b, fall0b;

  int errors = 0;
  int checks = 0;

  always #5 ck = ~ck;

  deglitch_filter dut_a (
    .CK(ck), .CD(cd), .CE(ce), .D0(d0),
    .Q0(q0), .QN0(qn0), .RISE0(rise0), .FALL0(fall0)
  );

  deglitch_filter #(.SYNC_STAGES(3), .STABLE_CNT(1), .RESET_VAL(1'b0)) dut_b (
    .CK(ck), .CD(cdb), .CE(1'b1), .D0(d0b),
    .Q0(q0b), .QN0(qn0b), .RISE0(rise0b), .FALL0(fall0b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ck);
      #1;
    end
  endtask

  task automatic check_q(input string tag, input logic q, input logic r, input logic f);
    logic qn, er, ef;
    qn = !q;
    er = EDGE_EN ? r : 1'b0;
    ef = EDGE_EN ? f : 1'b0;
    chk({tag, "_q"}, q0, q);
    chk({tag, "_qn"}, qn0, qn);
    chk({tag, "_rise"}, rise0, er);
    chk({tag, "_fall"}, fall0, ef);
  endtask

  task automatic do_reset(input logic din);
    cd = 1'b1;
    ce = 1'b1;
    d0 = din;
    tick(2);
    cd = 1'b0;
  endtask

  initial begin
    logic [3:0] h;
    logic eq, eqn, er, ef;

    // reset with D0 high, then release: Q0 rises at edge 6
    cd = 1'b1; ce = 1'b1; d0 = 1'b1; cdb = 1'b1; d0b = 1'b0;
    tick(2);
    check_q("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_b_q", q0b, 1'b0);
    chk("rst_b_qn", qn0b, 1'b1);
    cd = 1'b0; cdb = 1'b0;
    tick(5);
    check_q("rel_e5", 1'b0, 1'b0, 1'b0);
    tick(1);
    check_q("rel_e6", 1'b1, 1'b1, 1'b0);
    tick(1);
    check_q("rel_e7", 1'b1, 1'b0, 1'b0);

    // clean rise
    do_reset(1'b0);
    tick(2);
    d0 = 1'b1;
    tick(5);
    check_q("rise_e5", 1'b0, 1'b0, 1'b0);
    tick(1);
    check_q("rise_e6", 1'b1, 1'b1, 1'b0);
    tick(1);
    check_q("rise_e7", 1'b1, 1'b0, 1'b0);

    // 3-cycle glitch is discarded
    do_reset(1'b0);
    d0 = 1'b1;
    tick(3);
    d0 = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk($sformatf("glitch3_c%0d", i), q0, 1'b0);
    end

    // 4-cycle pulse passes: rise at edge 6, fall at edge 10
    d0 = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick(1);
      if (e == 4) d0 = 1'b0;
      check_q($sformatf("p4_e%0d", e), (e >= 6 && e <= 9), (e == 6), (e == 10));
    end

    // CE gating: count 2 reached at edge 4, gated for edges 5..9
    do_reset(1'b0);
    d0 = 1'b1;
    tick(4);
    ce = 1'b0;
    tick(5);
    check_q("ce_hold", 1'b0, 1'b0, 1'b0);
    ce = 1'b1;
    tick(1);
    check_q("ce_e10", 1'b0, 1'b0, 1'b0);
    tick(1);
    check_q("ce_e11", 1'b1, 1'b1, 1'b0);

    // reset while pending restarts the full latency
    do_reset(1'b0);
    d0 = 1'b1;
    tick(5);
    cd = 1'b1;
    tick(1);
    check_q("mid_rst", 1'b0, 1'b0, 1'b0);
    cd = 1'b0;
    tick(5);
    check_q("mid_e11", 1'b0, 1'b0, 1'b0);
    tick(1);
    check_q("mid_e12", 1'b1, 1'b1, 1'b0);

    // STABLE_CNT=1, SYNC_STAGES=3: Q0 equals D0 from three edges earlier
    h = 4'b0000;
    for (int e = 0; e < 40; e++) begin
      if (e % 4 == 0) d0b = ~d0b;
      tick(1);
      eq  = h[2];
      eqn = !h[2];
      er  = EDGE_EN ? (h[2] & !h[3]) : 1'b0;
      ef  = EDGE_EN ? (!h[2] & h[3]) : 1'b0;
      chk($sformatf("b_q_e%0d", e), q0b, eq);
      chk($sformatf("b_qn_e%0d", e), qn0b, eqn);
      chk($sformatf("b_rise_e%0d", e), rise0b, er);
      chk($sformatf("b_fall_e%0d", e), fall0b, ef);
      h = {h[2:0], d0b};
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
